// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the LED sequencing controller.
// Rev 1.0
`default_nettype none

package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_AUTO  = 2'd2
    } state_t;

    localparam logic [1:0] DIR_BOUNCE = 2'd0;
    localparam logic [1:0] DIR_RIGHT  = 2'd1;
    localparam logic [1:0] DIR_LEFT   = 2'd2;
    localparam logic [1:0] DIR_LIMIT  = 2'd2;

    localparam int BTN_DIR   = 0;
    localparam int BTN_SPEED = 1;
    localparam int BTN_PAUSE = 2;
    localparam int BTN_AUTO  = 3;

    // Pattern code 3 is never produced: wrap from the last valid code to bounce.
    function automatic logic [1:0] dir_next(input logic [1:0] d);
        return (d >= DIR_LIMIT) ? DIR_BOUNCE : d + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_seq_ctrl_step_timer.sv
// step_timer: free-running prescaler with a speed-selectable step-due detect.
// Rev 1.0
`default_nettype none

module step_timer #(
    parameter int TICK_LOG2 = 23
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       step_due
);

    logic [TICK_LOG2-1:0] cnt;
    logic [TICK_LOG2-1:0] mask;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Low (TICK_LOG2 - speed) bits all ones marks the last cycle of a period;
    // gated by en so a held count does not re-fire while paused.
    always_comb begin
        mask     = {TICK_LOG2{1'b1}} >> speed;
        step_due = en && ((cnt & mask) == mask);
    end

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: button arbiter, run/pause/auto FSM and STEP/RESTART generation
// for the LED pattern engine. Rev 1.0
`default_nettype none

module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_LOG2  = 23,
    parameter int AUTO_STEPS = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTNP,
    output logic [1:0] DIR,
    output logic [1:0] SPEED,
    output logic       STEP,
    output logic       RESTART,
    output logic       PAUSED,
    output logic       AUTO
);

    localparam int ACW = $clog2(AUTO_STEPS + 1);

    state_t         state, state_n;
    logic [3:0]     pending, pending_n;
    logic [3:0]     req, grant;
    logic [1:0]     dir_r, dir_n;
    logic [1:0]     speed_r, speed_n;
    logic [ACW-1:0] acnt, acnt_n, acnt_inc;
    logic           step_r, step_n;
    logic           restart_r, restart_n;
    logic           step_due;
    logic           timer_en;
    logic           timer_clr;
    logic           auto_hit;
    logic           dir_adv;

    step_timer #(
        .TICK_LOG2 (TICK_LOG2)
    ) u_step_timer (
        .CLK      (CLK),
        .RST      (RST),
        .en       (timer_en),
        .clr      (timer_clr),
        .speed    (speed_r),
        .step_due (step_due)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_RUN;
            pending   <= '0;
            dir_r     <= DIR_BOUNCE;
            speed_r   <= '0;
            acnt      <= '0;
            step_r    <= 1'b0;
            restart_r <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            dir_r     <= dir_n;
            speed_r   <= speed_n;
            acnt      <= acnt_n;
            step_r    <= step_n;
            restart_r <= restart_n;
        end
    end

    always_comb begin
        // Lowest set request wins; the rest wait, and repeat presses merge.
        req       = pending | BTNP;
        grant     = req & (~req + 4'd1);
        pending_n = req & ~grant;

        state_n   = state;
        speed_n   = speed_r;
        acnt_n    = acnt;
        acnt_inc  = acnt + 1'b1;
        auto_hit  = 1'b0;
        timer_en  = (state != ST_PAUSE);

        if (state == ST_AUTO && step_due) begin
            if (acnt_inc == ACW'(AUTO_STEPS)) begin
                acnt_n   = '0;
                auto_hit = 1'b1;
            end else begin
                acnt_n   = acnt_inc;
            end
        end

        if (grant[BTN_DIR]) begin
            acnt_n = '0;
        end

        if (grant[BTN_SPEED]) begin
            speed_n = speed_r + 2'd1;
        end

        if (grant[BTN_PAUSE]) begin
            state_n = (state == ST_PAUSE) ? ST_RUN : ST_PAUSE;
        end

        if (grant[BTN_AUTO]) begin
            if (state == ST_AUTO) begin
                state_n = ST_RUN;
            end else begin
                state_n = ST_AUTO;
                acnt_n  = '0;
            end
        end

        // A button advance and an auto advance in the same cycle count once.
        dir_adv   = grant[BTN_DIR] | auto_hit;
        dir_n     = dir_adv ? dir_next(dir_r) : dir_r;
        timer_clr = dir_adv | grant[BTN_SPEED];
        restart_n = dir_adv;
        step_n    = step_due & ~dir_adv;
    end

    assign DIR     = dir_r;
    assign SPEED   = speed_r;
    assign STEP    = step_r;
    assign RESTART = restart_r;
    assign PAUSED  = (state == ST_PAUSE);
    assign AUTO    = (state == ST_AUTO);

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: scoreboard bench for led_seq_ctrl with TICK_LOG2=4, AUTO_STEPS=3.
// Rev 1.0
`default_nettype none

module tb_led_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] BTNP;
    logic [1:0] DIR;
    logic [1:0] SPEED;
    logic       STEP;
    logic       RESTART;
    logic       PAUSED;
    logic       AUTO;

    led_seq_ctrl #(
        .TICK_LOG2  (4),
        .AUTO_STEPS (3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTNP    (BTNP),
        .DIR     (DIR),
        .SPEED   (SPEED),
        .STEP    (STEP),
        .RESTART (RESTART),
        .PAUSED  (PAUSED),
        .AUTO    (AUTO)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: state 0 run, 1 pause, 2 auto.
    int         m_state, m_dir, m_speed, m_cnt, m_acnt;
    logic [3:0] m_pend;
    bit         m_step, m_restart;

    logic [7:0] sb_q[$];

    int steps_seen, restarts_seen, run_edges, last_gap;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_due();
        int per;
        per = 16 >> m_speed;
        return (m_state != 1) && ((m_cnt % per) == per - 1);
    endfunction

    task automatic model_step(input logic [3:0] b, input logic r);
        int         g;
        logic [3:0] rq;
        bit         due, adv_btn, adv_auto;
        if (r) begin
            m_state = 0; m_dir = 0; m_speed = 0; m_cnt = 0; m_acnt = 0;
            m_pend = 4'd0; m_step = 0; m_restart = 0;
            return;
        end
        rq = m_pend | b;
        g  = -1;
        for (int i = 3; i >= 0; i--) if (rq[i]) g = i;
        m_pend = rq;
        if (g >= 0) m_pend[g] = 1'b0;
        due      = model_due();
        adv_btn  = (g == 0);
        adv_auto = 0;
        if (m_state == 2 && due) begin
            m_acnt++;
            if (m_acnt == 3) begin
                m_acnt   = 0;
                adv_auto = !adv_btn;
            end
        end
        if (adv_btn) m_acnt = 0;
        if (adv_btn || adv_auto || g == 1) m_cnt = 0;
        else if (m_state != 1)             m_cnt = (m_cnt + 1) % 16;
        if (g == 2) m_state = (m_state == 1) ? 0 : 1;
        if (g == 3) begin
            if (m_state == 2) m_state = 0;
            else begin
                m_state = 2;
                m_acnt  = 0;
            end
        end
        if (adv_btn || adv_auto) m_dir = (m_dir + 1) % 3;
        if (g == 1) m_speed = (m_speed + 1) % 4;
        m_restart = adv_btn || adv_auto;
        m_step    = due && !m_restart;
    endtask

    // One clock: drive, predict, then compare the registered outputs.
    task automatic tick(input logic [3:0] b, input logic r);
        logic [7:0] e, got;
        logic       pre_paused;
        BTNP = b;
        RST  = r;
        model_step(b, r);
        sb_q.push_back({m_dir[1:0], m_speed[1:0], m_step, m_restart,
                        (m_state == 1), (m_state == 2)});
        pre_paused = PAUSED;
        @(posedge CLK);
        #1;
        got = {DIR, SPEED, STEP, RESTART, PAUSED, AUTO};
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val("outputs", {24'd0, got}, {24'd0, e});
        end
        if (r) begin
            run_edges = 0;
        end else begin
            if (!pre_paused) run_edges++;
            if (STEP) begin
                steps_seen++;
                last_gap  = run_edges;
                run_edges = 0;
            end
            if (RESTART) restarts_seen++;
        end
    endtask

    task automatic do_reset();
        repeat (2) tick(4'd0, 1'b1);
        steps_seen = 0; restarts_seen = 0; run_edges = 0; last_gap = 0;
    endtask

    initial begin
        int  first, k, prev_dir;
        bit  found;
        BTNP = 4'd0;
        RST  = 1'b1;
        steps_seen = 0; restarts_seen = 0; run_edges = 0; last_gap = 0;
        do_reset();
        check_val("reset_outs", {24'd0, DIR, SPEED, STEP, RESTART, PAUSED, AUTO}, 32'd0);

        // Free running at slowest speed.
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(4'd0, 1'b0);
            if (STEP && first == 0) first = i;
        end
        check_val("t1_first_step", first, 16);
        check_val("t1_step_count", steps_seen, 2);

        // Simultaneous DIR and SPEED presses: serviced on consecutive cycles.
        do_reset();
        tick(4'b0011, 1'b0);
        check_val("t2_dir", DIR, 1);
        check_val("t2_restart", RESTART, 1);
        tick(4'd0, 1'b0);
        check_val("t2_speed", SPEED, 1);
        k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            tick(4'd0, 1'b0);
            if (STEP) k = i;
        end
        check_val("t2_step_after_speed", k, 8);

        // Three direction presses.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            tick(4'b0001, 1'b0);
            check_val("t3_dir", DIR, (p + 1) % 3);
            repeat (4) tick(4'd0, 1'b0);
        end
        check_val("t3_restarts", restarts_seen, 3);

        // Pause holds the prescaler; resume finishes the partial period.
        do_reset();
        repeat (20) tick(4'd0, 1'b0);
        tick(4'b0100, 1'b0);
        check_val("t4_paused", PAUSED, 1);
        steps_seen = 0;
        repeat (100) tick(4'd0, 1'b0);
        check_val("t4_pause_steps", steps_seen, 0);
        tick(4'b0100, 1'b0);
        check_val("t4_resumed", PAUSED, 0);
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            tick(4'd0, 1'b0);
            if (STEP) k = i;
        end
        check_val("t4_resume_step_seen", (k != 0), 1);
        check_val("t4_resume_step_at", k, 11);
        check_val("t4_running_gap", last_gap, 16);

        // Auto demo at top speed.
        do_reset();
        repeat (3) begin
            tick(4'b0010, 1'b0);
            tick(4'd0, 1'b0);
        end
        check_val("t5_speed", SPEED, 3);
        tick(4'b1000, 1'b0);
        check_val("t5_auto", AUTO, 1);
        restarts_seen = 0;
        repeat (30) tick(4'd0, 1'b0);
        check_val("t5_auto_restarts", restarts_seen, 5);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_state == 2 && model_due() && m_acnt == 2) begin
                prev_dir = int'(DIR);
                tick(4'b0001, 1'b0);
                check_val("t5_coinc_dir", DIR, (prev_dir + 1) % 3);
                check_val("t5_coinc_restart", RESTART, 1);
                found = 1;
            end else begin
                tick(4'd0, 1'b0);
            end
        end
        check_val("t5_coinc_found", found, 1);
        repeat (12) tick(4'd0, 1'b0);

        // Reset right after a full burst discards every pending request.
        do_reset();
        tick(4'b1111, 1'b0);
        tick(4'd0, 1'b1);
        check_val("t6_after_rst", {24'd0, DIR, SPEED, STEP, RESTART, PAUSED, AUTO}, 32'd0);
        restarts_seen = 0;
        repeat (20) tick(4'd0, 1'b0);
        check_val("t6_restarts", restarts_seen, 0);
        check_val("t6_state", {30'd0, PAUSED, AUTO}, 32'd0);
        check_val("t6_speed", SPEED, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
